// File: rtl/sram_1rw_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_1rw_req_ctrl
//  Purpose  : Request controller in front of a single-port (1RW) SRAM macro.
//             It merges independent ready/valid write and read request
//             channels onto the macro's en/wmode/addr/wmask/wdata port, one
//             access per cycle. Writes and reads are arbitrated round-robin
//             when they contend. Read data, which arrives one cycle after
//             issue, is captured into a 2-entry response FIFO with ready/valid
//             backpressure. After reset the array is zero-filled before any
//             request is accepted.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   sole clock, shared with the SRAM macro
//    rst_n            in   asynchronous reset, active low
//    i_w_req_valid    in   write request valid
//    o_w_req_ready    out  write request accepted this cycle
//    i_w_req_addr     in   [ADDR_W] write address
//    i_w_req_data     in   [DATA_W] write data
//    i_w_req_mask     in   [DATA_W] bit-write mask, 1 = write that bit
//    i_r_req_valid    in   read request valid
//    o_r_req_ready    out  read request accepted this cycle
//    i_r_req_addr     in   [ADDR_W] read address
//    o_r_resp_valid   out  response FIFO holds data
//    i_r_resp_ready   in   consumer takes the head response
//    o_r_resp_data    out  [DATA_W] head response data
//    o_sram_en        out  macro access enable
//    o_sram_wmode     out  1 = write, 0 = read
//    o_sram_addr      out  [ADDR_W] macro address
//    o_sram_wmask     out  [DATA_W] macro bit-write mask
//    o_sram_wdata     out  [DATA_W] macro write data
//    i_sram_rdata     in   [DATA_W] macro read data, valid the cycle after a read
// ============================================================================
module sram_1rw_req_ctrl #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_w_req_valid,
    output logic              o_w_req_ready,
    input  logic [ADDR_W-1:0] i_w_req_addr,
    input  logic [DATA_W-1:0] i_w_req_data,
    input  logic [DATA_W-1:0] i_w_req_mask,

    input  logic              i_r_req_valid,
    output logic              o_r_req_ready,
    input  logic [ADDR_W-1:0] i_r_req_addr,

    output logic              o_r_resp_valid,
    input  logic              i_r_resp_ready,
    output logic [DATA_W-1:0] o_r_resp_data,

    output logic              o_sram_en,
    output logic              o_sram_wmode,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wmask,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]        ST_INIT      = 1'b0;
    localparam logic [0:0]        ST_RUN       = 1'b1;
    localparam logic [ADDR_W-1:0] C_LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam int                C_FIFO_DEPTH = 2;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_init_idx;

    // 1 = the most recent grant went to the write channel
    logic              r_last_grant_w;
    // a read was issued last cycle; its data is on i_sram_rdata now
    logic              r_inflight;

    logic [DATA_W-1:0] r_fifo_mem [C_FIFO_DEPTH];
    logic              r_fifo_wr_ptr;
    logic              r_fifo_rd_ptr;
    logic [1:0]        r_fifo_count;

    logic              w_run;
    logic              w_push;
    logic              w_pop;
    logic [2:0]        w_occupancy;
    logic              w_rd_ok;
    logic              w_rd_cand;
    logic              w_grant_w;
    logic              w_grant_r;

    // ------------------------------------------------------------------------
    // Response FIFO status and read eligibility
    // ------------------------------------------------------------------------
    assign w_run  = (r_state == ST_RUN);
    assign w_push = r_inflight;
    assign w_pop  = o_r_resp_valid & i_r_resp_ready;

    // Slots already promised: buffered responses plus the read in flight,
    // minus the one leaving this cycle. A new read is only safe when this
    // leaves room for its data two cycles from now. pop implies count >= 1,
    // so the subtraction never underflows.
    assign w_occupancy = {1'b0, r_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_ok     = (w_occupancy < 3'd2);

    // ------------------------------------------------------------------------
    // Arbitration: contested cycles alternate, otherwise a valid write wins
    // and an eligible read takes any otherwise idle cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_cand = 1'b0;
        w_grant_w = 1'b0;
        w_grant_r = 1'b0;
        if (w_run) begin
            w_rd_cand = i_r_req_valid & w_rd_ok;
            if (i_w_req_valid && w_rd_cand) begin
                w_grant_w = ~r_last_grant_w;
                w_grant_r =  r_last_grant_w;
            end else begin
                w_grant_w = i_w_req_valid;
                w_grant_r = w_rd_cand;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_init_idx == C_LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs to the macro and the request channels
    // ------------------------------------------------------------------------
    always_comb begin
        o_sram_en     = 1'b0;
        o_sram_wmode  = 1'b0;
        o_sram_addr   = '0;
        o_sram_wmask  = '0;
        o_sram_wdata  = '0;
        o_w_req_ready = 1'b0;
        o_r_req_ready = 1'b0;
        case (r_state)
            ST_INIT: begin
                // zero-fill one entry per cycle, full mask
                o_sram_en    = 1'b1;
                o_sram_wmode = 1'b1;
                o_sram_addr  = r_init_idx;
                o_sram_wmask = '1;
            end
            ST_RUN: begin
                o_w_req_ready = w_grant_w;
                o_r_req_ready = w_grant_r;
                if (w_grant_w) begin
                    o_sram_en    = 1'b1;
                    o_sram_wmode = 1'b1;
                    o_sram_addr  = i_w_req_addr;
                    o_sram_wmask = i_w_req_mask;
                    o_sram_wdata = i_w_req_data;
                end else if (w_grant_r) begin
                    o_sram_en    = 1'b1;
                    o_sram_addr  = i_r_req_addr;
                end
            end
            default: begin
                o_sram_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Init index, arbitration history and read-in-flight flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_idx     <= '0;
            r_last_grant_w <= 1'b0;
            r_inflight     <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_idx <= r_init_idx + ADDR_W'(1);
            end
            if (w_grant_w || w_grant_r) begin
                r_last_grant_w <= w_grant_w;
            end
            r_inflight <= w_grant_r;
        end
    end

    // ------------------------------------------------------------------------
    // Response FIFO: push the macro data in the cycle after a read issue;
    // push and pop may coincide. Eligibility gating guarantees no overflow.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_FIFO_DEPTH; i++) begin
                r_fifo_mem[i] <= '0;
            end
            r_fifo_wr_ptr <= 1'b0;
            r_fifo_rd_ptr <= 1'b0;
            r_fifo_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_fifo_wr_ptr] <= i_sram_rdata;
                r_fifo_wr_ptr             <= ~r_fifo_wr_ptr;
            end
            if (w_pop) begin
                r_fifo_rd_ptr <= ~r_fifo_rd_ptr;
            end
            r_fifo_count <= r_fifo_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_r_resp_valid = (r_fifo_count != 2'd0);
    assign o_r_resp_data  = r_fifo_mem[r_fifo_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_1rw_req_ctrl
//  Purpose  : Self-checking bench for sram_1rw_req_ctrl. Contains a masked
//             1-cycle-latency SRAM macro model, a table of directed vectors,
//             a randomized phase checked against a transaction-level
//             reference model, and a reset-during-traffic sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_1rw_req_ctrl;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 1;
    localparam int DATA_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_w_req_valid = 1'b0;
    logic              o_w_req_ready;
    logic [ADDR_W-1:0] i_w_req_addr = '0;
    logic [DATA_W-1:0] i_w_req_data = '0;
    logic [DATA_W-1:0] i_w_req_mask = '0;
    logic              i_r_req_valid = 1'b0;
    logic              o_r_req_ready;
    logic [ADDR_W-1:0] i_r_req_addr = '0;
    logic              o_r_resp_valid;
    logic              i_r_resp_ready = 1'b0;
    logic [DATA_W-1:0] o_r_resp_data;
    logic              o_sram_en;
    logic              o_sram_wmode;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] o_sram_wmask;
    logic [DATA_W-1:0] o_sram_wdata;
    logic [DATA_W-1:0] i_sram_rdata = '0;

    always #5 clk = ~clk;

    sram_1rw_req_ctrl #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_w_req_valid (i_w_req_valid),
        .o_w_req_ready (o_w_req_ready),
        .i_w_req_addr  (i_w_req_addr),
        .i_w_req_data  (i_w_req_data),
        .i_w_req_mask  (i_w_req_mask),
        .i_r_req_valid (i_r_req_valid),
        .o_r_req_ready (o_r_req_ready),
        .i_r_req_addr  (i_r_req_addr),
        .o_r_resp_valid(o_r_resp_valid),
        .i_r_resp_ready(i_r_resp_ready),
        .o_r_resp_data (o_r_resp_data),
        .o_sram_en     (o_sram_en),
        .o_sram_wmode  (o_sram_wmode),
        .o_sram_addr   (o_sram_addr),
        .o_sram_wmask  (o_sram_wmask),
        .o_sram_wdata  (o_sram_wdata),
        .i_sram_rdata  (i_sram_rdata)
    );

    // ------------------------------------------------------------------------
    // SRAM macro model: masked write, read data one cycle after issue,
    // garbage on the read port in every other cycle.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] sram_arr [DEPTH];

    always @(posedge clk) begin
        if (o_sram_en && o_sram_wmode) begin
            sram_arr[o_sram_addr] <= (sram_arr[o_sram_addr] & ~o_sram_wmask) |
                                     (o_sram_wdata & o_sram_wmask);
        end
        if (o_sram_en && !o_sram_wmode) begin
            i_sram_rdata <= sram_arr[o_sram_addr];
        end else begin
            i_sram_rdata <= 4'($urandom);
        end
    end

    // ------------------------------------------------------------------------
    // Scoring
    // ------------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Observed output bundle: {w_ready, r_ready, resp_valid, en, wmode, addr, wmask, wdata}
    function automatic logic [13:0] observed();
        return {o_w_req_ready, o_r_req_ready, o_r_resp_valid, o_sram_en,
                o_sram_wmode, o_sram_addr, o_sram_wmask, o_sram_wdata};
    endfunction

    task automatic drive(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] wm, input logic rv, input logic [ADDR_W-1:0] ra,
                         input logic rr);
        i_w_req_valid  = wv;
        i_w_req_addr   = wa;
        i_w_req_data   = wd;
        i_w_req_mask   = wm;
        i_r_req_valid  = rv;
        i_r_req_addr   = ra;
        i_r_resp_ready = rr;
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic              wv;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] wm;
        logic              rv;
        logic [ADDR_W-1:0] ra;
        logic              rr;
        logic [13:0]       exp;
        logic              erv;
        logic [DATA_W-1:0] erd;
    } vec_t;

    function automatic vec_t V(input int wv, input int wa, input int wd, input int wm,
                               input int rv, input int ra, input int rr,
                               input int xwr, input int xrr, input int xrv, input int xrd,
                               input int xen, input int xwmode, input int xaddr,
                               input int xmask, input int xwdata);
        vec_t v;
        v.wv  = 1'(wv);
        v.wa  = ADDR_W'(wa);
        v.wd  = 4'(wd);
        v.wm  = 4'(wm);
        v.rv  = 1'(rv);
        v.ra  = ADDR_W'(ra);
        v.rr  = 1'(rr);
        v.erv = 1'(xrv);
        v.erd = 4'(xrd);
        v.exp = {1'(xwr), 1'(xrr), 1'(xrv), 1'(xen), 1'(xwmode), ADDR_W'(xaddr),
                 4'(xmask), 4'(xwdata)};
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Transaction-level reference model: memory image, queue of promised
    // responses stamped with the cycle they become visible, grant history.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } resp_t;

    logic [DATA_W-1:0] m_mem [DEPTH];
    resp_t             m_q [$];
    int                m_cyc;
    bit                m_last_w;

    task automatic model_reset();
        m_cyc    = 0;
        m_last_w = 1'b0;
        m_q.delete();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic mstep(input string tag, input logic wv, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] wm,
                         input logic rv, input logic [ADDR_W-1:0] ra, input logic rr);
        logic              vis, pop, rdok, rc, gw, gr;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_mask, e_wdata;
        logic [13:0]       exp;
        resp_t             r;
        drive(wv, wa, wd, wm, rv, ra, rr);
        #1;
        vis = 1'b0; pop = 1'b0; gw = 1'b0; gr = 1'b0;
        if (m_cyc < DEPTH) begin
            exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ADDR_W'(m_cyc), 4'hF, 4'h0};
        end else begin
            vis  = (m_q.size() > 0) && (m_q[0].due <= m_cyc);
            pop  = vis && rr;
            rdok = (m_q.size() - int'(pop)) < 2;
            rc   = rv && rdok;
            if (wv && rc) begin
                gw = !m_last_w;
                gr = m_last_w;
            end else begin
                gw = wv;
                gr = rc;
            end
            e_addr  = gw ? wa : (gr ? ra : '0);
            e_mask  = gw ? wm : '0;
            e_wdata = gw ? wd : '0;
            exp = {gw, gr, vis, gw | gr, gw, e_addr, e_mask, e_wdata};
        end
        check($sformatf("%s_c%0d_outs", tag, m_cyc), 32'(observed()), 32'(exp));
        if (vis) begin
            check($sformatf("%s_c%0d_rdata", tag, m_cyc), 32'(o_r_resp_data), 32'(m_q[0].data));
        end
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (gr) begin
            r.data = m_mem[ra];
            r.due  = m_cyc + 2;
            m_q.push_back(r);
        end
        if (gw) m_mem[wa] = (m_mem[wa] & ~wm) | (wd & wm);
        if (gw || gr) m_last_w = gw;
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t tbl [37];

    initial begin
        // wv wa wd wm  rv ra rr | wr rr rv rd | en wm ad mask wdata
        tbl[0]  = V(0,0,0,0,   1,1,1,  0,0,0,0,  1,1,0,'hF,0);
        tbl[1]  = V(0,0,0,0,   1,1,1,  0,0,0,0,  1,1,1,'hF,0);
        tbl[2]  = V(0,0,0,0,   1,1,1,  0,1,0,0,  1,0,1,0,0);
        tbl[3]  = V(0,0,0,0,   0,0,1,  0,0,0,0,  0,0,0,0,0);
        tbl[4]  = V(0,0,0,0,   0,0,1,  0,0,1,0,  0,0,0,0,0);
        tbl[5]  = V(1,1,'hA,'hF, 0,0,1, 1,0,0,0, 1,1,1,'hF,'hA);
        tbl[6]  = V(0,0,0,0,   1,1,1,  0,1,0,0,  1,0,1,0,0);
        tbl[7]  = V(0,0,0,0,   0,0,1,  0,0,0,0,  0,0,0,0,0);
        tbl[8]  = V(0,0,0,0,   0,0,1,  0,0,1,'hA, 0,0,0,0,0);
        tbl[9]  = V(1,1,5,3,   0,0,1,  1,0,0,0,  1,1,1,3,5);
        tbl[10] = V(0,0,0,0,   1,1,1,  0,1,0,0,  1,0,1,0,0);
        tbl[11] = V(0,0,0,0,   0,0,1,  0,0,0,0,  0,0,0,0,0);
        tbl[12] = V(0,0,0,0,   0,0,1,  0,0,1,9,  0,0,0,0,0);
        tbl[13] = V(0,0,0,0,   1,0,1,  0,1,0,0,  1,0,0,0,0);
        tbl[14] = V(0,0,0,0,   1,1,1,  0,1,0,0,  1,0,1,0,0);
        tbl[15] = V(0,0,0,0,   1,0,1,  0,1,1,0,  1,0,0,0,0);
        tbl[16] = V(0,0,0,0,   1,1,1,  0,1,1,9,  1,0,1,0,0);
        tbl[17] = V(0,0,0,0,   0,0,1,  0,0,1,0,  0,0,0,0,0);
        tbl[18] = V(0,0,0,0,   0,0,1,  0,0,1,9,  0,0,0,0,0);
        tbl[19] = V(0,0,0,0,   0,0,1,  0,0,0,0,  0,0,0,0,0);
        tbl[20] = V(0,0,0,0,   1,0,0,  0,1,0,0,  1,0,0,0,0);
        tbl[21] = V(0,0,0,0,   1,1,0,  0,1,0,0,  1,0,1,0,0);
        tbl[22] = V(1,0,3,'hF, 1,0,0,  1,0,1,0,  1,1,0,'hF,3);
        tbl[23] = V(0,0,0,0,   1,0,0,  0,0,1,0,  0,0,0,0,0);
        tbl[24] = V(0,0,0,0,   1,0,1,  0,1,1,0,  1,0,0,0,0);
        tbl[25] = V(0,0,0,0,   0,0,1,  0,0,1,9,  0,0,0,0,0);
        tbl[26] = V(0,0,0,0,   0,0,1,  0,0,1,3,  0,0,0,0,0);
        tbl[27] = V(0,0,0,0,   0,0,1,  0,0,0,0,  0,0,0,0,0);
        tbl[28] = V(1,0,6,'hF, 1,1,1,  1,0,0,0,  1,1,0,'hF,6);
        tbl[29] = V(1,0,6,'hF, 1,1,1,  0,1,0,0,  1,0,1,0,0);
        tbl[30] = V(1,0,6,'hF, 1,1,1,  1,0,0,0,  1,1,0,'hF,6);
        tbl[31] = V(1,0,6,'hF, 1,1,1,  0,1,1,9,  1,0,1,0,0);
        tbl[32] = V(1,0,6,'hF, 1,1,1,  1,0,0,0,  1,1,0,'hF,6);
        tbl[33] = V(1,0,6,'hF, 1,1,1,  0,1,1,9,  1,0,1,0,0);
        tbl[34] = V(0,0,0,0,   0,0,1,  0,0,0,0,  0,0,0,0,0);
        tbl[35] = V(0,0,0,0,   0,0,1,  0,0,1,9,  0,0,0,0,0);
        tbl[36] = V(0,0,0,0,   0,0,1,  0,0,0,0,  0,0,0,0,0);

        // ---------------- directed table after a reset release -------------
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 37; i++) begin
            drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].wm, tbl[i].rv, tbl[i].ra, tbl[i].rr);
            #1;
            check($sformatf("vec%0d_outs", i), 32'(observed()), 32'(tbl[i].exp));
            if (tbl[i].erv) begin
                check($sformatf("vec%0d_rdata", i), 32'(o_r_resp_data), 32'(tbl[i].erd));
            end
            @(posedge clk);
            @(negedge clk);
        end

        // ---------------- randomized traffic against the model -------------
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic rr;
            rr = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            mstep("rand", 1'($urandom_range(0, 1)), ADDR_W'($urandom), 4'($urandom),
                  4'($urandom), 1'($urandom_range(0, 2) != 0), ADDR_W'($urandom), rr);
        end

        // ---------------- reset with a buffered and an in-flight read ------
        for (int k = 0; k < 8 && m_q.size() > 0; k++) begin
            mstep("drain", 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        end
        mstep("bp_rd0", 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        mstep("bp_rd1", 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, '0, 4'h7, 4'hF, 1'b1, '0, 1'b0);
        #1;
        check("pre_reset_resp_valid", 32'(o_r_resp_valid),
              32'((m_q.size() > 0) && (m_q[0].due <= m_cyc)));
        rst_n = 1'b0;
        #1;
        check("in_reset_outs", 32'(observed()),
              32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ADDR_W'(0), 4'hF, 4'h0}));
        check("in_reset_rdata", 32'(o_r_resp_data), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            mstep("post_reset", 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        end
        mstep("post_reset_rd", 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            mstep("post_reset", 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
